uart_tx_pkt_arbiter: RTL and testbench

Shares the single byte-serial UART transmitter between several packet sources, e.g. the controller-report sender and a debug/status sender. Each source requests transmission of a 1-4 byte packet. The arbiter grants sources round-robin at packet boundaries, captures the granted packet and feeds its bytes LSB-first to the transmitter using the trmt/tx_done handshake. It then acknowledges the source and enforces a programmable idle gap before the next packet.

---
 rtl/uart_host_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/uart_tx_pkt_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_pkt_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_pkg.sv
// Definitions shared by the UART host-side blocks: arbiter FSM states,
// packet limits and the request byte used by the host-side request decoder.
package uart_host_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_DONE,
      GAP
   } uart_arb_state_t;

   localparam int unsigned MAX_PKT_BYTES = 4;
   localparam logic [7:0]  UART_REQ_BYTE = 8'hC6;

   // Lengths above the packet capacity are sent as full packets.
   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      return (len > 3'(MAX_PKT_BYTES)) ? 3'(MAX_PKT_BYTES) : len;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: picks the first active request at or
// above ptr_i, wrapping past N-1 back to 0.
module rr_arbiter #(
   parameter int N = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o
);

   logic [IW:0] pos;
   logic        found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      pos     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = {1'b0, ptr_i} + (IW+1)'(i);
         if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
         if (!found && req_i[pos[IW-1:0]]) begin
            found                  = 1'b1;
            grant_o[pos[IW-1:0]]   = 1'b1;
            idx_o                  = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_pkt_arbiter.sv
// Shares one byte-serial UART transmitter between NUM_REQ packet sources:
// round-robin grant per packet, LSB-first byte feed, ack, optional idle gap.
module uart_tx_pkt_arbiter
   import uart_host_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int GAP_CYCLES = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [32*NUM_REQ-1:0]  pkt_data,
   input  logic [3*NUM_REQ-1:0]   pkt_len,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     ack,
   output logic                   tx_trmt,
   output logic [7:0]             tx_data,
   input  logic                   tx_done,
   output logic                   busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   uart_arb_state_t      state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 trmt_q, trmt_d;
   logic [7:0]           txd_q, txd_d;
   logic [31:0]          shift_q, shift_d;
   logic [2:0]           rem_q, rem_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [IW-1:0]        win_q, win_d;

   logic [NUM_REQ-1:0]   arb_grant;
   logic [IW-1:0]        arb_idx;
   logic [31:0]          data_arr [NUM_REQ];
   logic [2:0]           len_arr  [NUM_REQ];
   logic [2:0]           sel_len;
   logic                 done_ok;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign data_arr[g] = pkt_data[32*g +: 32];
      assign len_arr[g]  = pkt_len[3*g +: 3];
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx)
   );

   assign sel_len = clamp_len(len_arr[arb_idx]);
   // A tx_done coinciding with the start pulse belongs to no byte of ours.
   assign done_ok = tx_done & ~trmt_q;

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      trmt_d  = 1'b0;
      txd_d   = txd_q;
      shift_d = shift_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d   = arb_grant;
               win_d   = arb_idx;
               shift_d = data_arr[arb_idx];
               rem_d   = sel_len;
               state_d = WAIT_DONE;
               if (sel_len != 3'd0) begin
                  trmt_d = 1'b1;
                  txd_d  = data_arr[arb_idx][7:0];
               end
            end
         end
         SEND: begin
            shift_d = shift_q >> 8;
            txd_d   = shift_q[15:8];
            trmt_d  = 1'b1;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            // rem_q == 0 only for zero-length packets: finish without sending.
            if (rem_q == 3'd0 || (done_ok && rem_q == 3'd1)) begin
               ack_d = gnt_q;
               gnt_d = '0;
               rem_d = '0;
               ptr_d = (win_q == LAST_IDX) ? '0 : win_q + IW'(1);
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  gap_d   = GAP_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end else if (done_ok) begin
               rem_d   = rem_q - 3'd1;
               state_d = SEND;
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - GW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ack_q   <= '0;
         trmt_q  <= 1'b0;
         txd_q   <= '0;
         shift_q <= '0;
         rem_q   <= '0;
         gap_q   <= '0;
         ptr_q   <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         trmt_q  <= trmt_d;
         txd_q   <= txd_d;
         shift_q <= shift_d;
         rem_q   <= rem_d;
         gap_q   <= gap_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
      end
   end

   assign gnt     = gnt_q;
   assign ack     = ack_q;
   assign tx_trmt = trmt_q;
   assign tx_data = txd_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_pkt_arbiter.sv
// Directed bench for uart_tx_pkt_arbiter: byte and grant scoreboards, a
// transmitter model answering each start pulse with tx_done 10 cycles later.
module tb_uart_tx_pkt_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [1:0]  a_req, a_gnt, a_ack;
   logic [63:0] a_pkt_data;
   logic [5:0]  a_pkt_len;
   logic        a_trmt, a_done, a_busy;
   logic [7:0]  a_data;

   logic [1:0]  b_req, b_gnt, b_ack;
   logic [63:0] b_pkt_data;
   logic [5:0]  b_pkt_len;
   logic        b_trmt, b_done, b_busy;
   logic [7:0]  b_data;

   uart_tx_pkt_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0)) dut (
      .clk(clk), .rst_n(rst_n), .req(a_req), .pkt_data(a_pkt_data), .pkt_len(a_pkt_len),
      .gnt(a_gnt), .ack(a_ack), .tx_trmt(a_trmt), .tx_data(a_data), .tx_done(a_done),
      .busy(a_busy)
   );

   uart_tx_pkt_arbiter #(.NUM_REQ(2), .GAP_CYCLES(5)) dut_gap (
      .clk(clk), .rst_n(rst_n), .req(b_req), .pkt_data(b_pkt_data), .pkt_len(b_pkt_len),
      .gnt(b_gnt), .ack(b_ack), .tx_trmt(b_trmt), .tx_data(b_data), .tx_done(b_done),
      .busy(b_busy)
   );

   int n_assert, n_fail, cyc, inv_err;
   logic [7:0] exp_bytes [$];
   logic [1:0] exp_gnt [$];

   int trmt_cnt, ack_cnt, last_ack_cyc, gnt_rise_cyc, done_cyc, a_cd;
   logic [1:0] last_ack, prev_gnt;
   logic pend_done, auto_drop, inj_idle, inj_trmt;

   int b_cd, b_trmt_cnt, b_ack_cnt, b_gapcnt, b_last_gap, b_rise_cyc, b_last_trmt_cyc;
   logic [1:0] b_prev_gnt, b_rise_gnt;
   logic [7:0] b_last_data;
   logic b_in_gap;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (a_trmt) begin
         trmt_cnt++;
         if (exp_bytes.size() == 0) chk("a_byte_unexpected", 32'(a_data), 32'hFFFF_FFFF);
         else                       chk("a_tx_data", 32'(a_data), 32'(exp_bytes.pop_front()));
         if (pend_done) chk("a_done_to_trmt", 32'(cyc - done_cyc), 32'd2);
         pend_done = 1'b0;
      end
      if (a_gnt != 2'b00 && prev_gnt == 2'b00) begin
         gnt_rise_cyc = cyc;
         if (exp_gnt.size() == 0) chk("a_gnt_unexpected", 32'(a_gnt), 32'd0);
         else                     chk("a_gnt", 32'(a_gnt), 32'(exp_gnt.pop_front()));
      end
      if (a_ack != 2'b00) begin
         ack_cnt++;
         last_ack     = a_ack;
         last_ack_cyc = cyc;
         chk("a_ack_vs_prev_gnt", 32'(a_ack), 32'(prev_gnt));
         chk("a_gnt_clear_at_ack", 32'(a_gnt), 32'd0);
         pend_done = 1'b0;
         if (auto_drop) a_req = a_req & ~a_ack;
      end
      if (!$onehot0(a_gnt) || !$onehot0(a_ack) || (a_busy && a_gnt == 2'b00)) inv_err++;
      prev_gnt = a_gnt;
      a_done = 1'b0;
      if (a_trmt) a_cd = 10;
      else if (a_cd > 0) begin
         a_cd--;
         if (a_cd == 0) begin
            a_done    = 1'b1;
            pend_done = 1'b1;
            done_cyc  = cyc;
         end
      end
      if (inj_idle) begin a_done = 1'b1; inj_idle = 1'b0; end
      if (inj_trmt && a_trmt) begin a_done = 1'b1; inj_trmt = 1'b0; end

      if (b_trmt) begin
         b_trmt_cnt++;
         b_last_data     = b_data;
         b_last_trmt_cyc = cyc;
      end
      if (b_ack != 2'b00) begin
         b_ack_cnt++;
         b_gapcnt = 0;
         b_in_gap = 1'b1;
         if (auto_drop) b_req = b_req & ~b_ack;
      end
      if (b_in_gap && b_busy && b_gnt == 2'b00) b_gapcnt++;
      if (b_gnt != 2'b00 && b_prev_gnt == 2'b00) begin
         b_rise_gnt = b_gnt;
         b_rise_cyc = cyc;
         if (b_in_gap) b_last_gap = b_gapcnt;
         b_in_gap = 1'b0;
      end
      b_prev_gnt = b_gnt;
      b_done = 1'b0;
      if (b_trmt) b_cd = 10;
      else if (b_cd > 0) begin
         b_cd--;
         if (b_cd == 0) b_done = 1'b1;
      end
   endtask

   task automatic wait_a_ack(input string tag, input int n);
      int start = ack_cnt;
      int k = 0;
      while (ack_cnt < start + n && k < 500) begin tick(); k++; end
      chk(tag, 32'(ack_cnt - start), 32'(n));
   endtask

   task automatic wait_b_ack(input string tag, input int n);
      int start = b_ack_cnt;
      int k = 0;
      while (b_ack_cnt < start + n && k < 500) begin tick(); k++; end
      chk(tag, 32'(b_ack_cnt - start), 32'(n));
   endtask

   initial begin
      int t0, a0, k;
      n_assert = 0; n_fail = 0; cyc = 0; inv_err = 0;
      trmt_cnt = 0; ack_cnt = 0; last_ack_cyc = 0; gnt_rise_cyc = 0; done_cyc = 0; a_cd = 0;
      last_ack = '0; prev_gnt = '0; pend_done = 0; auto_drop = 1; inj_idle = 0; inj_trmt = 0;
      b_cd = 0; b_trmt_cnt = 0; b_ack_cnt = 0; b_gapcnt = 0; b_last_gap = -1; b_rise_cyc = 0;
      b_last_trmt_cyc = -1; b_prev_gnt = '0; b_rise_gnt = '0; b_last_data = '0; b_in_gap = 0;
      rst_n = 1'b0;
      a_req = '0; a_pkt_data = '0; a_pkt_len = '0; a_done = 1'b0;
      b_req = '0; b_pkt_data = {32'h0000_00B1, 32'h0000_00B0}; b_pkt_len = {3'd1, 3'd1}; b_done = 1'b0;

      repeat (3) tick();
      chk("rst_gnt", 32'(a_gnt), 32'd0);
      chk("rst_ack", 32'(a_ack), 32'd0);
      chk("rst_trmt", 32'(a_trmt), 32'd0);
      chk("rst_data", 32'(a_data), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single 4-byte packet from source 0.
      a_pkt_data = {32'h0, 32'hDDCC_BBAA};
      a_pkt_len  = {3'd0, 3'd4};
      exp_bytes.push_back(8'hAA); exp_bytes.push_back(8'hBB);
      exp_bytes.push_back(8'hCC); exp_bytes.push_back(8'hDD);
      exp_gnt.push_back(2'b01);
      t0 = trmt_cnt;
      a_req = 2'b01;
      wait_a_ack("t1_ack", 1);
      chk("t1_trmt_count", 32'(trmt_cnt - t0), 32'd4);
      chk("t1_ack_src", 32'(last_ack), 32'b01);
      chk("t1_ack_latency", 32'(last_ack_cyc - done_cyc), 32'd1);
      chk("t1_busy_low", 32'(a_busy), 32'd0);
      chk("t1_bytes_left", 32'(exp_bytes.size()), 32'd0);

      // Zero-length packet, then an over-length packet clamped to 4 bytes.
      a_pkt_data = {32'h4433_2211, 32'h5555_5555};
      a_pkt_len  = {3'd6, 3'd0};
      exp_gnt.push_back(2'b01);
      t0 = trmt_cnt;
      a_req = 2'b01;
      wait_a_ack("t3_len0_ack", 1);
      chk("t3_len0_no_trmt", 32'(trmt_cnt - t0), 32'd0);
      chk("t3_len0_ack_src", 32'(last_ack), 32'b01);
      chk("t3_len0_ack_after_gnt", 32'(last_ack_cyc - gnt_rise_cyc), 32'd1);
      chk("t3_len0_busy_low", 32'(a_busy), 32'd0);
      exp_bytes.push_back(8'h11); exp_bytes.push_back(8'h22);
      exp_bytes.push_back(8'h33); exp_bytes.push_back(8'h44);
      exp_gnt.push_back(2'b10);
      t0 = trmt_cnt;
      a_req = 2'b10;
      wait_a_ack("t3_len6_ack", 1);
      chk("t3_len6_trmt_count", 32'(trmt_cnt - t0), 32'd4);
      chk("t3_len6_ack_src", 32'(last_ack), 32'b10);

      // Both sources requesting continuously: grants alternate 0,1,0,1.
      a_pkt_data = {32'h0000_2322, 32'h0000_0011};
      a_pkt_len  = {3'd2, 3'd1};
      for (int i = 0; i < 2; i++) begin
         exp_bytes.push_back(8'h11); exp_bytes.push_back(8'h22); exp_bytes.push_back(8'h23);
         exp_gnt.push_back(2'b01);   exp_gnt.push_back(2'b10);
      end
      auto_drop = 1'b0;
      a_req = 2'b11;
      wait_a_ack("t2_acks", 4);
      a_req = 2'b00;
      auto_drop = 1'b1;
      repeat (3) tick();
      chk("t2_busy_low", 32'(a_busy), 32'd0);
      chk("t2_bytes_left", 32'(exp_bytes.size()), 32'd0);
      chk("t2_gnts_left", 32'(exp_gnt.size()), 32'd0);

      // Spurious tx_done in IDLE and with the start pulse; data changed mid-packet.
      a0 = ack_cnt; t0 = trmt_cnt;
      inj_idle = 1'b1;
      repeat (2) tick();
      chk("t4_idle_done_busy", 32'(a_busy), 32'd0);
      chk("t4_idle_done_ack", 32'(ack_cnt - a0), 32'd0);
      chk("t4_idle_done_trmt", 32'(trmt_cnt - t0), 32'd0);
      a_pkt_data = {32'h0, 32'h0000_5A5B};
      a_pkt_len  = {3'd0, 3'd2};
      exp_bytes.push_back(8'h5B); exp_bytes.push_back(8'h5A);
      exp_gnt.push_back(2'b01);
      inj_trmt = 1'b1;
      a_req = 2'b01;
      k = 0;
      while (trmt_cnt == t0 && k < 50) begin tick(); k++; end
      chk("t4_first_trmt", 32'(trmt_cnt - t0), 32'd1);
      t0 = cyc;
      a_pkt_data = {32'h0, 32'hFFFF_FFFF};
      a_pkt_len  = {3'd0, 3'd4};
      wait_a_ack("t4_ack", 1);
      chk("t4_ack_timing", 32'(last_ack_cyc - t0), 32'd23);
      chk("t4_bytes_left", 32'(exp_bytes.size()), 32'd0);

      // Reset after the second byte of a source-1 packet aborts it.
      a_pkt_data = {32'h0000_7776, 32'h0};
      a_pkt_len  = {3'd2, 3'd0};
      exp_bytes.push_back(8'h76); exp_bytes.push_back(8'h77);
      exp_gnt.push_back(2'b10);
      t0 = trmt_cnt;
      a_req = 2'b10;
      k = 0;
      while (trmt_cnt < t0 + 2 && k < 100) begin tick(); k++; end
      chk("t5_two_bytes", 32'(trmt_cnt - t0), 32'd2);
      rst_n = 1'b0; a_req = 2'b00; a_cd = 0; pend_done = 1'b0;
      tick();
      chk("t5_rst_gnt", 32'(a_gnt), 32'd0);
      chk("t5_rst_ack", 32'(a_ack), 32'd0);
      chk("t5_rst_trmt", 32'(a_trmt), 32'd0);
      chk("t5_rst_data", 32'(a_data), 32'd0);
      chk("t5_rst_busy", 32'(a_busy), 32'd0);
      rst_n = 1'b1;
      a0 = ack_cnt; t0 = trmt_cnt;
      repeat (20) tick();
      chk("t5_no_ack", 32'(ack_cnt - a0), 32'd0);
      chk("t5_no_trmt", 32'(trmt_cnt - t0), 32'd0);
      a_pkt_data = {32'h0000_0088, 32'h0000_0099};
      a_pkt_len  = {3'd1, 3'd1};
      exp_bytes.push_back(8'h99); exp_bytes.push_back(8'h88);
      exp_gnt.push_back(2'b01);   exp_gnt.push_back(2'b10);
      a_req = 2'b11;
      wait_a_ack("t5_after_rst_acks", 2);
      chk("t5_bytes_left", 32'(exp_bytes.size()), 32'd0);

      // Idle gap of 5 cycles on the second instance.
      b_req = 2'b11;
      wait_b_ack("g_ack1", 1);
      chk("g_first_gnt", 32'(b_rise_gnt), 32'b01);
      wait_b_ack("g_ack2", 1);
      chk("g_gap_cycles", 32'(b_last_gap), 32'd5);
      chk("g_second_gnt", 32'(b_rise_gnt), 32'b10);
      chk("g_trmt_with_gnt", 32'(b_last_trmt_cyc - b_rise_cyc), 32'd0);
      chk("g_second_byte", 32'(b_last_data), 32'hB1);
      repeat (4) tick();
      chk("g_busy_in_gap", 32'(b_busy), 32'd1);
      tick();
      chk("g_busy_after_gap", 32'(b_busy), 32'd0);
      chk("g_trmt_count", 32'(b_trmt_cnt), 32'd2);

      chk("invariants", 32'(inv_err), 32'd0);
      chk("gnts_left", 32'(exp_gnt.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
